// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide controller: MDU op codes,
// arithmetic-unit op codes and controller state constants.
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] CALC_MULT  = 2'd0;
    localparam logic [1:0] CALC_MULTU = 2'd1;
    localparam logic [1:0] CALC_DIV   = 2'd2;
    localparam logic [1:0] CALC_DIVU  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic [1:0] calc_of(input logic [2:0] op);
        logic [1:0] c;
        case (op)
            OP_MULTU: c = CALC_MULTU;
            OP_DIV:   c = CALC_DIV;
            OP_DIVU:  c = CALC_DIVU;
            default:  c = CALC_MULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: launches the external arithmetic unit,
// enforces the architectural latency and owns the HI/LO registers.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_valid,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        calc_start,
    output logic [1:0]  calc_op,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    input  logic        calc_done,
    input  logic [31:0] calc_hi,
    input  logic [31:0] calc_lo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_seen_q, done_seen_d;
    logic             start_q, start_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_seen_d = done_seen_q;
        start_d     = 1'b0;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hold_hi_d   = hold_hi_q;
        hold_lo_d   = hold_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                // A flushed E (req) must neither launch nor write HI/LO.
                if (op_valid && !req) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d         = rs_val;
                            b_d         = rt_val;
                            op_d        = calc_of(mdu_op);
                            start_d     = 1'b1;
                            done_seen_d = 1'b0;
                            state_d     = ST_RUN;
                            cnt_d       = (mdu_op == OP_DIV || mdu_op == OP_DIVU)
                                          ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    // A result arriving on the final cycle beats an older held one.
                    if (calc_done) begin
                        hi_d        = calc_hi;
                        lo_d        = calc_lo;
                        done_seen_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (done_seen_q) begin
                        hi_d        = hold_hi_q;
                        lo_d        = hold_lo_q;
                        done_seen_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (calc_done) begin
                        hold_hi_d   = calc_hi;
                        hold_lo_d   = calc_lo;
                        done_seen_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (calc_done) begin
                    hi_d        = calc_hi;
                    lo_d        = calc_lo;
                    done_seen_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
            start_q     <= 1'b0;
            op_q        <= CALC_MULT;
            a_q         <= '0;
            b_q         <= '0;
            hold_hi_q   <= '0;
            hold_lo_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_seen_q <= done_seen_d;
            start_q     <= start_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hold_hi_q   <= hold_hi_d;
            hold_lo_q   <= hold_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign calc_start = start_q;
    assign calc_op    = op_q;
    assign calc_a     = a_q;
    assign calc_b     = b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a vector table of single ops with hand-computed
// latencies and HI/LO results, plus hand sequences for reset and idle results.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        calc_start;
    logic [1:0]  calc_op;
    logic [31:0] calc_a, calc_b;
    logic        calc_done = 1'b0;
    logic [31:0] calc_hi = '0, calc_lo = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_hi = '0, prev_lo = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .op_valid(op_valid), .mdu_op(mdu_op),
        .rs_val(rs_val), .rt_val(rt_val), .calc_start(calc_start), .calc_op(calc_op),
        .calc_a(calc_a), .calc_b(calc_b), .calc_done(calc_done), .calc_hi(calc_hi),
        .calc_lo(calc_lo), .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt;
        logic        req;      // req at the accept edge
        int          req_cyc;  // cycle after accept where req pulses (0 = none)
        int          d1;       // cycle of first calc_done (0 = none)
        logic [31:0] h1, l1;
        int          d2;       // cycle of second calc_done (0 = none)
        logic [31:0] h2, l2;
        int          e_busy;
        logic [1:0]  e_op;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic rq, input int rq_cyc,
                                input int d1, input logic [31:0] h1, input logic [31:0] l1,
                                input int d2, input logic [31:0] h2, input logic [31:0] l2,
                                input int e_busy, input logic [1:0] e_op,
                                input logic [31:0] e_hi, input logic [31:0] e_lo);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.req = rq; v.req_cyc = rq_cyc;
        v.d1 = d1; v.h1 = h1; v.l1 = l1; v.d2 = d2; v.h2 = h2; v.l2 = l2;
        v.e_busy = e_busy; v.e_op = e_op; v.e_hi = e_hi; v.e_lo = e_lo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int busy_n = 0, start_n = 0, start_cyc = 0;
        logic [31:0] last_hi = prev_hi, last_lo = prev_lo;
        @(negedge clk);
        op_valid = 1'b1; mdu_op = v.op; rs_val = v.rs; rt_val = v.rt; req = v.req;
        @(negedge clk);
        op_valid = 1'b0; req = 1'b0; rs_val = 32'hDEAD_0000; rt_val = 32'h0000_DEAD;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (!busy) break;
            busy_n++;
            last_hi = hi; last_lo = lo;
            if (calc_start) begin
                start_n++;
                start_cyc = cyc;
                chk({tag, " calc_op"}, {30'd0, calc_op}, {30'd0, v.e_op});
                chk({tag, " calc_a"}, calc_a, v.rs);
                chk({tag, " calc_b"}, calc_b, v.rt);
            end
            req = (cyc == v.req_cyc);
            calc_done = (cyc == v.d1) || (cyc == v.d2);
            calc_hi = (cyc == v.d2) ? v.h2 : v.h1;
            calc_lo = (cyc == v.d2) ? v.l2 : v.l1;
            @(negedge clk);
            calc_done = 1'b0; req = 1'b0;
        end
        chk({tag, " busy cycles"}, busy_n, v.e_busy);
        chk({tag, " start pulses"}, start_n, (v.e_busy > 0) ? 1 : 0);
        if (start_n > 0) chk({tag, " start cycle"}, start_cyc, 1);
        if (busy_n > 0) begin
            chk({tag, " hi held while busy"}, last_hi, prev_hi);
            chk({tag, " lo held while busy"}, last_lo, prev_lo);
        end
        chk({tag, " hi"}, hi, v.e_hi);
        chk({tag, " lo"}, lo, v.e_lo);
        prev_hi = v.e_hi; prev_lo = v.e_lo;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = mk(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                     0, 0, 0, 5, CALC_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        vecs[1] = mk(OP_DIVU, 32'd7, 32'd2, 1'b0, 0, 13, 32'd1, 32'd3,
                     0, 0, 0, 13, CALC_DIVU, 32'd1, 32'd3);
        vecs[2] = mk(OP_MTHI, 32'h1234, 32'd0, 1'b0, 0, 0, 0, 0,
                     0, 0, 0, 0, CALC_MULT, 32'h1234, 32'd3);
        vecs[3] = mk(OP_MTLO, 32'h5555, 32'd0, 1'b1, 0, 0, 0, 0,
                     0, 0, 0, 0, CALC_MULT, 32'h1234, 32'd3);
        vecs[4] = mk(OP_DIV, 32'd9, 32'd3, 1'b1, 0, 0, 0, 0,
                     0, 0, 0, 0, CALC_DIV, 32'h1234, 32'd3);
        vecs[5] = mk(OP_MULT, 32'd3, 32'd4, 1'b0, 2, 2, 32'd0, 32'd12,
                     0, 0, 0, 5, CALC_MULT, 32'd0, 32'd12);
        vecs[6] = mk(OP_MULTU, 32'h1_0000, 32'h1_0000, 1'b0, 0, 5, 32'd1, 32'd0,
                     0, 0, 0, 5, CALC_MULTU, 32'd1, 32'd0);
        vecs[7] = mk(OP_DIV, 32'd5, 32'd0, 1'b0, 0, 4, 32'd5, 32'hFFFF_FFFF,
                     0, 0, 0, 10, CALC_DIV, 32'd5, 32'hFFFF_FFFF);
        vecs[8] = mk(3'd7, 32'h7777, 32'h7777, 1'b0, 0, 0, 0, 0,
                     0, 0, 0, 0, CALC_MULT, 32'd5, 32'hFFFF_FFFF);
        vecs[9] = mk(OP_MTLO, 32'hABCD, 32'd0, 1'b0, 0, 0, 0, 0,
                     0, 0, 0, 0, CALC_MULT, 32'd5, 32'hABCD);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset start", {31'd0, calc_start}, 32'd0);
        chk("reset calc_op", {30'd0, calc_op}, 32'd0);
        chk("reset calc_a", calc_a, 32'd0);
        chk("reset calc_b", calc_b, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Held result followed by a second pulse on the final RUN cycle.
        run_vec("double done", mk(OP_MULT, 32'd6, 32'd7, 1'b0, 0, 2, 32'hDEAD, 32'hBEEF,
                                  5, 32'd0, 32'd42, 5, CALC_MULT, 32'd0, 32'd42));

        // Results offered while idle are ignored.
        @(negedge clk);
        calc_done = 1'b1; calc_hi = 32'h9999; calc_lo = 32'h8888;
        @(negedge clk);
        calc_done = 1'b0;
        @(negedge clk);
        chk("idle done busy", {31'd0, busy}, 32'd0);
        chk("idle done hi", hi, 32'd0);
        chk("idle done lo", lo, 32'd42);

        // Reset in the middle of a divide.
        op_valid = 1'b1; mdu_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        chk("mid reset calc_a", calc_a, 32'd0);
        chk("mid reset calc_op", {30'd0, calc_op}, 32'd0);
        prev_hi = 32'd0; prev_lo = 32'd0;
        run_vec("post reset", mk(OP_MULTU, 32'd10, 32'd20, 1'b0, 0, 3, 32'd0, 32'd200,
                                 0, 0, 0, 5, CALC_MULTU, 32'd0, 32'd200));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
